// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the pixel-source bus and the DAC-side outputs of vga_timing_gen.
//   vga_data    : 24-bit pixel returned by the source ([23:16]=R, [15:8]=G, [7:0]=B)
//   h_addr      : active-area column requested from the source (0 outside active)
//   v_addr      : active-area row requested from the source (0 outside active)
//   hsync/vsync : active-low sync pulses, aligned with the colour outputs
//   valid       : output pixel lies in the active area
//   vga_r/g/b   : registered colour, 0 during blanking
//   frame_start : one-cycle pulse on output pixel (0,0)
// Modports:
//   master : the timing generator (drives addresses and DAC outputs)
//   slave  : the pixel source / display side
// ----------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;

  modport master (
    input  vga_data,
    output h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    output vga_data,
    input  h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Free-running pixel/line counters for a VGA raster. Presents active-area
// addresses to the pixel source, takes the source's data back PIX_LAT clocks
// later and registers sync, blank and RGB so every output leaves on the same
// clock, PIX_LAT+1 cycles after the counter value that produced it.
// Ports:
//   clk : pixel clock
//   rst : synchronous, active-low reset
//   vga : vga_timing_gen_if.master (addresses out, vga_data in, DAC outputs)
// Parameters:
//   H_SYNC/H_BP/H_DISP/H_FP : line segments in clocks (sync, back porch,
//                             active, front porch)
//   V_SYNC/V_BP/V_DISP/V_FP : frame segments in lines
//   PIX_LAT                 : source latency from address to data, 0..3
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned PIX_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  // Counter boundaries, pre-sized to the 10-bit counter width.
  localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BP + H_DISP + H_FP - 1);
  localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BP + V_DISP + V_FP - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_DISP);
  localparam logic [9:0] V_ACT_BEG   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_DISP);

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  logic [9:0] x_cnt_q, x_cnt_d;
  logic [9:0] y_cnt_q, y_cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    x_cnt_d = x_cnt_q + 10'd1;
    y_cnt_d = y_cnt_q;
    if (x_cnt_q == H_LAST) begin
      x_cnt_d = '0;
      y_cnt_d = (y_cnt_q == V_LAST) ? 10'd0 : y_cnt_q + 10'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: decode straight from the counter registers
  // --------------------------------------------------------------------------
  logic h_act, v_act;
  logic hs0, vs0, act0, fs0;

  always_comb begin
    h_act = (x_cnt_q >= H_ACT_BEG) && (x_cnt_q < H_ACT_END);
    v_act = (y_cnt_q >= V_ACT_BEG) && (y_cnt_q < V_ACT_END);
    hs0   = (x_cnt_q >= H_SYNC_END);
    vs0   = (y_cnt_q >= V_SYNC_END);
    act0  = h_act && v_act;
    fs0   = (x_cnt_q == 10'd0) && (y_cnt_q == 10'd0);
  end

  assign vga.h_addr = h_act ? (x_cnt_q - H_ACT_BEG) : 10'd0;
  assign vga.v_addr = v_act ? (y_cnt_q - V_ACT_BEG) : 10'd0;

  // --------------------------------------------------------------------------
  // Delay line: PIX_LAT+1 register stages per control bit.
  // Each *_c vector is the whole chain with the stage-0 value in bit 0, so
  // bit k is the value delayed by k clocks; this keeps PIX_LAT=0 legal
  // without a separate code path.
  // --------------------------------------------------------------------------
  logic [PIX_LAT:0]   hs_q,  hs_d,  vs_q,  vs_d;
  logic [PIX_LAT:0]   act_q, act_d, fs_q,  fs_d;
  logic [PIX_LAT+1:0] hs_c,  vs_c,  act_c, fs_c;

  assign hs_c  = {hs_q,  hs0};
  assign vs_c  = {vs_q,  vs0};
  assign act_c = {act_q, act0};
  assign fs_c  = {fs_q,  fs0};

  assign hs_d  = hs_c[PIX_LAT:0];
  assign vs_d  = vs_c[PIX_LAT:0];
  assign act_d = act_c[PIX_LAT:0];
  assign fs_d  = fs_c[PIX_LAT:0];

  // --------------------------------------------------------------------------
  // RGB register: act delayed by PIX_LAT lines up with the source's data for
  // the same pixel; during blanking the source is ignored so stale data
  // cannot reach the DAC.
  // --------------------------------------------------------------------------
  logic [23:0] rgb_q, rgb_d;

  assign rgb_d = act_c[PIX_LAT] ? vga.vga_data : 24'd0;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; every register, including the
    // RGB data path, is cleared so the pins are quiet while rst is low.
    if (!rst) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      act_q   <= '0;
      fs_q    <= '0;
      rgb_q   <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      act_q   <= act_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: last stage of each chain, all PIX_LAT+1 clocks after stage 0
  // --------------------------------------------------------------------------
  assign vga.hsync       = hs_c[PIX_LAT+1];
  assign vga.vsync       = vs_c[PIX_LAT+1];
  assign vga.valid       = act_c[PIX_LAT+1];
  assign vga.frame_start = fs_c[PIX_LAT+1];
  assign vga.vga_r       = rgb_q[23:16];
  assign vga.vga_g       = rgb_q[15:8];
  assign vga.vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances (PIX_LAT = 0, 1, 3) with a shrunken raster so several whole
// frames fit in a short run. Expected outputs come from a frame-index model:
// the cycle count since reset release gives the raster position directly, and
// every output is that position's decode, PIX_LAT+1 cycles late.
// Pixel sources return {4'h0, h_addr, v_addr} after PIX_LAT clocks; whenever
// the model says the returned pixel is blank, random junk is driven instead.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HS = 5, HB = 3, HD = 12, HF = 4;
  localparam int VS = 2, VB = 3, VD = 6,  VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] junk_val = '0;
  logic        junk0 = 1'b0, junk1 = 1'b0, junk3 = 1'b0;
  int          n = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if3 ();

  vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
                   .V_SYNC(VS), .V_BP(VB), .V_DISP(VD), .V_FP(VF), .PIX_LAT(0))
    dut0 (.clk(clk), .rst(rst), .vga(if0));
  vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
                   .V_SYNC(VS), .V_BP(VB), .V_DISP(VD), .V_FP(VF), .PIX_LAT(1))
    dut1 (.clk(clk), .rst(rst), .vga(if1));
  vga_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
                   .V_SYNC(VS), .V_BP(VB), .V_DISP(VD), .V_FP(VF), .PIX_LAT(3))
    dut3 (.clk(clk), .rst(rst), .vga(if3));

  // Pixel sources with 0, 1 and 3 clocks of latency.
  logic [19:0] src1_q;
  logic [19:0] src3_q [3];
  always @(posedge clk) begin
    src1_q    <= {if1.h_addr, if1.v_addr};
    src3_q[0] <= {if3.h_addr, if3.v_addr};
    src3_q[1] <= src3_q[0];
    src3_q[2] <= src3_q[1];
  end

  assign if0.vga_data = !rst ? 24'hFFFFFF : junk0 ? junk_val : {4'h0, if0.h_addr, if0.v_addr};
  assign if1.vga_data = !rst ? 24'hFFFFFF : junk1 ? junk_val : {4'h0, src1_q};
  assign if3.vga_data = !rst ? 24'hFFFFFF : junk3 ? junk_val : {4'h0, src3_q[2]};

  exp_t obs0, obs1, obs3;
  assign obs0 = {if0.h_addr, if0.v_addr, if0.hsync, if0.vsync, if0.valid, if0.frame_start,
                 if0.vga_r, if0.vga_g, if0.vga_b};
  assign obs1 = {if1.h_addr, if1.v_addr, if1.hsync, if1.vsync, if1.valid, if1.frame_start,
                 if1.vga_r, if1.vga_g, if1.vga_b};
  assign obs3 = {if3.h_addr, if3.v_addr, if3.hsync, if3.vsync, if3.valid, if3.frame_start,
                 if3.vga_r, if3.vga_g, if3.vga_b};

  // ---------------------------------------------------------------- model
  function automatic bit in_h(int x);
    return (x >= HS + HB) && (x < HS + HB + HD);
  endfunction

  function automatic bit in_v(int y);
    return (y >= VS + VB) && (y < VS + VB + VD);
  endfunction

  function automatic bit act_at(int k);
    return in_h(k % HT) && in_v((k / HT) % VT);
  endfunction

  // Expected pins in the cycle that is `cyc` cycles after reset release.
  function automatic exp_t ref_out(int lat, int cyc);
    exp_t e;
    int   k, x, y, m;
    k = cyc % FRAME;
    x = k % HT;
    y = k / HT;
    e.h_addr = in_h(x) ? 10'(x - HS - HB) : 10'd0;
    e.v_addr = in_v(y) ? 10'(y - VS - VB) : 10'd0;
    m = cyc - lat - 1;
    if (m < 0) begin
      e.hsync = 1'b1;
      e.vsync = 1'b1;
      e.valid = 1'b0;
      e.fs    = 1'b0;
      e.rgb   = 24'd0;
    end else begin
      k = m % FRAME;
      x = k % HT;
      y = k / HT;
      e.hsync = (x >= HS);
      e.vsync = (y >= VS);
      e.valid = in_h(x) && in_v(y);
      e.fs    = (k == 0);
      e.rgb   = e.valid ? {4'h0, 10'(x - HS - HB), 10'(y - VS - VB)} : 24'd0;
    end
    return e;
  endfunction

  // True when the data the DUT samples this cycle is for a blank pixel.
  function automatic bit src_idle(int lat);
    return (n < lat) || !act_at(n - lat);
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic compare(string nm, exp_t o, exp_t e);
    check({nm, " h_addr"},      32'(o.h_addr), 32'(e.h_addr));
    check({nm, " v_addr"},      32'(o.v_addr), 32'(e.v_addr));
    check({nm, " hsync"},       32'(o.hsync),  32'(e.hsync));
    check({nm, " vsync"},       32'(o.vsync),  32'(e.vsync));
    check({nm, " valid"},       32'(o.valid),  32'(e.valid));
    check({nm, " frame_start"}, 32'(o.fs),     32'(e.fs));
    check({nm, " rgb"},         32'(o.rgb),    32'(e.rgb));
  endtask

  // Independent run-length measurements on the PIX_LAT=1 instance.
  bit meas_en = 1'b0;
  bit prev_hs = 1'b1, prev_vs = 1'b1, prev_valid = 1'b0;
  int hlow = 0, vlow = 0, vrun = 0;
  int last_hfall = -1, last_fs = -1;
  int hmax = 0, vmax = 0;

  task automatic measure();
    if (prev_hs && !obs1.hsync) begin
      if (last_hfall >= 0) check("hsync period", n - last_hfall, HT);
      last_hfall = n;
    end
    if (!obs1.hsync) hlow++;
    else begin
      if (!prev_hs) check("hsync low width", hlow, HS);
      hlow = 0;
    end
    if (prev_vs && !obs1.vsync) check("vsync fall on frame_start", 32'(obs1.fs), 1);
    if (!obs1.vsync) vlow++;
    else begin
      if (!prev_vs) check("vsync low width", vlow, VS * HT);
      vlow = 0;
    end
    if (obs1.valid) vrun++;
    else begin
      if (prev_valid) check("valid run per line", vrun, HD);
      vrun = 0;
    end
    if (obs1.fs) begin
      if (last_fs >= 0) check("frame_start period", n - last_fs, FRAME);
      last_fs = n;
    end
    if (int'(obs1.h_addr) > hmax) hmax = int'(obs1.h_addr);
    if (int'(obs1.v_addr) > vmax) vmax = int'(obs1.v_addr);
    prev_hs    = obs1.hsync;
    prev_vs    = obs1.vsync;
    prev_valid = obs1.valid;
  endtask

  // One clock: drive inputs for the current cycle, advance, check at negedge.
  task automatic step(input logic rst_v);
    rst      = rst_v;
    junk_val = 24'($urandom);
    junk0    = src_idle(0);
    junk1    = src_idle(1);
    junk3    = src_idle(3);
    @(posedge clk);
    n = rst_v ? n + 1 : 0;
    @(negedge clk);
    compare("lat0", obs0, ref_out(0, n));
    compare("lat1", obs1, ref_out(1, n));
    compare("lat3", obs3, ref_out(3, n));
    if (meas_en) measure();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int target;

    // Reset held for 5 cycles with the source driving all ones.
    repeat (5) step(1'b0);

    // Free run over three frames with run-length measurements.
    meas_en = 1'b1;
    repeat (3 * FRAME + 10) step(1'b1);
    meas_en = 1'b0;
    check("h_addr max", hmax, HD - 1);
    check("v_addr max", vmax, VD - 1);

    // One-cycle reset in the middle of a random active line.
    target = (VS + VB + int'($urandom_range(0, VD - 1))) * HT + int'($urandom_range(0, HT - 1));
    for (int i = 0; i < FRAME; i++) begin
      if ((n % FRAME) == target) break;
      step(1'b1);
    end
    check("mid-frame reset position reached", n % FRAME, target);
    step(1'b0);
    repeat (FRAME + 20) step(1'b1);

    // Random resets of random length at random points.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(50, 400)) step(1'b1);
      repeat ($urandom_range(1, 3)) step(1'b0);
    end
    repeat (FRAME + 10) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
